// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  // Tracker Tnew width; Tnew/Tuse fields of up to 8 bits are supported.
  localparam int unsigned TNEW_W    = 8;
  // Any Tuse at or above this value marks the operand as unused.
  localparam int unsigned TUSE_NONE = 4;

  // Forwarding select encoding: 0 = register file, k+1 = result of stage k.
  localparam int unsigned FWD_RF         = 0;
  localparam int unsigned FWD_STAGE_BASE = 1;

  // MDU start codes presented in E.
  localparam logic [1:0] MD_START_NONE = 2'b00;
  localparam logic [1:0] MD_START_MULT = 2'b01;
  localparam logic [1:0] MD_START_DIV  = 2'b10;

  // One in-flight instruction past Decode.
  typedef struct packed {
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        a3;
    logic              we;
    logic [TNEW_W-1:0] tnew;
  } trk_entry_t;

  // Tnew saturating decrement applied as an entry moves down the pipe.
  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

endpackage

// File: rtl/mdu_busy_counter.sv
// mdu_busy_counter: multiply/divide busy tracker, loaded by an E-stage start.
module mdu_busy_counter
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_start,
  output logic       o_busy
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);

  logic [CW-1:0] r_count;
  logic          r_busy;
  logic [CW-1:0] w_count_nxt;

  // Next count: a start (re)loads the latency, otherwise count down to zero.
  always_comb begin
    w_count_nxt = r_count;
    if (i_start == MD_START_MULT) begin
      w_count_nxt = CW'(MULT_LAT);
    end else if (i_start == MD_START_DIV) begin
      w_count_nxt = CW'(DIV_LAT);
    end else if (r_count != '0) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Count and busy flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_busy  <= (w_count_nxt != '0);
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: D-stage stall and D/E forwarding selects from a Tnew tracker.
// Optional MDU busy stalls are built when HAZARD_MDU_EN is defined.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter  int unsigned NUM_STAGES = 3,
  parameter  int unsigned TW         = 3,
  localparam int unsigned FW         = $clog2(NUM_STAGES + 1)
`ifdef HAZARD_MDU_EN
  ,
  parameter  int unsigned MULT_LAT   = 5,
  parameter  int unsigned DIV_LAT    = 10
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    rs_d,
  input  logic [4:0]    rt_d,
  input  logic [TW-1:0] tuse_rs_d,
  input  logic [TW-1:0] tuse_rt_d,
  input  logic [4:0]    a3_d,
  input  logic          rfwe_d,
  input  logic [TW-1:0] tnew_d,
  output logic          stall,
  output logic [FW-1:0] fwd_rs_d,
  output logic [FW-1:0] fwd_rt_d,
  output logic [FW-1:0] fwd_rs_e,
  output logic [FW-1:0] fwd_rt_e
`ifdef HAZARD_MDU_EN
  ,
  input  logic          md_d,
  input  logic [1:0]    md_start_e,
  output logic          mdu_busy
`endif
);

  trk_entry_t r_trk  [NUM_STAGES];
  trk_entry_t w_next [NUM_STAGES];

  logic       w_haz_rs;
  logic       w_haz_rt;
  logic       w_mdu_stall;
  logic       w_stall;

  // Youngest-producer search for both D sources; older matches are shadowed.
  always_comb begin
    w_haz_rs = 1'b0;
    w_haz_rt = 1'b0;
    fwd_rs_d = FW'(FWD_RF);
    fwd_rt_d = FW'(FWD_RF);
    for (int k = int'(NUM_STAGES) - 1; k >= 0; k--) begin
      if (r_trk[k].we && (r_trk[k].a3 != 5'd0) && (r_trk[k].a3 == rs_d)) begin
        w_haz_rs = (32'(tuse_rs_d) < TUSE_NONE) &&
                   (r_trk[k].tnew > TNEW_W'(tuse_rs_d));
        fwd_rs_d = (r_trk[k].tnew == '0) ? FW'(k + int'(FWD_STAGE_BASE)) : FW'(FWD_RF);
      end
      if (r_trk[k].we && (r_trk[k].a3 != 5'd0) && (r_trk[k].a3 == rt_d)) begin
        w_haz_rt = (32'(tuse_rt_d) < TUSE_NONE) &&
                   (r_trk[k].tnew > TNEW_W'(tuse_rt_d));
        fwd_rt_d = (r_trk[k].tnew == '0) ? FW'(k + int'(FWD_STAGE_BASE)) : FW'(FWD_RF);
      end
    end
  end

  // E-stage operand forwarding from stages 1..NUM_STAGES-1, youngest first.
  always_comb begin
    fwd_rs_e = FW'(FWD_RF);
    fwd_rt_e = FW'(FWD_RF);
    for (int k = int'(NUM_STAGES) - 1; k >= 1; k--) begin
      if (r_trk[k].we && (r_trk[k].a3 != 5'd0) && (r_trk[k].a3 == r_trk[0].rs)) begin
        fwd_rs_e = (r_trk[k].tnew == '0) ? FW'(k + int'(FWD_STAGE_BASE)) : FW'(FWD_RF);
      end
      if (r_trk[k].we && (r_trk[k].a3 != 5'd0) && (r_trk[k].a3 == r_trk[0].rt)) begin
        fwd_rt_e = (r_trk[k].tnew == '0) ? FW'(k + int'(FWD_STAGE_BASE)) : FW'(FWD_RF);
      end
    end
  end

`ifdef HAZARD_MDU_EN
  logic w_mdu_busy;

  mdu_busy_counter #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_mdu_busy_counter (
    .clk     (clk),
    .reset   (reset),
    .i_start (md_start_e),
    .o_busy  (w_mdu_busy)
  );

  assign mdu_busy    = w_mdu_busy;
  assign w_mdu_stall = md_d && (w_mdu_busy || (md_start_e != MD_START_NONE));
`else
  assign w_mdu_stall = 1'b0;
`endif

  // Reset gating keeps stall low while reset is held, whatever the inputs.
  assign w_stall = !reset && (w_haz_rs || w_haz_rt || w_mdu_stall);
  assign stall   = w_stall;

  // Next tracker contents: bubble or D fields into E, aged shift below.
  always_comb begin
    w_next[0] = '0;
    if (!w_stall) begin
      w_next[0].rs   = rs_d;
      w_next[0].rt   = rt_d;
      w_next[0].a3   = a3_d;
      w_next[0].we   = rfwe_d;
      w_next[0].tnew = TNEW_W'(tnew_d);
    end
    for (int k = 1; k < int'(NUM_STAGES); k++) begin
      w_next[k]      = r_trk[k-1];
      w_next[k].tnew = tnew_dec(r_trk[k-1].tnew);
    end
  end

  // Tracker registers; reset empties every stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(NUM_STAGES); k++) begin
        r_trk[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(NUM_STAGES); k++) begin
        r_trk[k] <= w_next[k];
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed checks of stall and forwarding selects.
// Define HAZARD_MDU_EN to also exercise the MDU busy tracker.
module tb_hazard_unit;

  localparam int unsigned FW = 2;

  logic          clk;
  logic          reset;
  logic [4:0]    rs_d;
  logic [4:0]    rt_d;
  logic [2:0]    tuse_rs_d;
  logic [2:0]    tuse_rt_d;
  logic [4:0]    a3_d;
  logic          rfwe_d;
  logic [2:0]    tnew_d;
  logic          stall;
  logic [FW-1:0] fwd_rs_d;
  logic [FW-1:0] fwd_rt_d;
  logic [FW-1:0] fwd_rs_e;
  logic [FW-1:0] fwd_rt_e;
`ifdef HAZARD_MDU_EN
  logic          md_d;
  logic [1:0]    md_start_e;
  logic          mdu_busy;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  hazard_unit dut (
    .clk       (clk),
    .reset     (reset),
    .rs_d      (rs_d),
    .rt_d      (rt_d),
    .tuse_rs_d (tuse_rs_d),
    .tuse_rt_d (tuse_rt_d),
    .a3_d      (a3_d),
    .rfwe_d    (rfwe_d),
    .tnew_d    (tnew_d),
    .stall     (stall),
    .fwd_rs_d  (fwd_rs_d),
    .fwd_rt_d  (fwd_rt_d),
    .fwd_rs_e  (fwd_rs_e),
    .fwd_rt_e  (fwd_rt_e)
`ifdef HAZARD_MDU_EN
    ,
    .md_d       (md_d),
    .md_start_e (md_start_e),
    .mdu_busy   (mdu_busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [2:0] trs, input logic [2:0] trt,
                       input logic [4:0] a3, input logic we, input logic [2:0] tn);
    rs_d      = rs;
    rt_d      = rt;
    tuse_rs_d = trs;
    tuse_rt_d = trt;
    a3_d      = a3;
    rfwe_d    = we;
    tnew_d    = tn;
  endtask

  task automatic nop_d();
    set_d(5'd0, 5'd0, 3'd7, 3'd7, 5'd0, 1'b0, 3'd0);
  endtask

  task automatic flush();
    nop_d();
    repeat (4) tick();
  endtask

  initial begin
    reset = 1'b0;
    nop_d();
`ifdef HAZARD_MDU_EN
    md_d       = 1'b0;
    md_start_e = 2'b00;
`endif
    #1 reset = 1'b1;
    #1;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_fwd_rs_d", 32'(fwd_rs_d), 32'd0);
    chk("reset_fwd_rs_e", 32'(fwd_rs_e), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Load-use: lw $8 (Tnew 2) followed by addu using $8 with Tuse 1.
    set_d(5'd29, 5'd0, 3'd1, 3'd7, 5'd8, 1'b1, 3'd2);
    #1 chk("lu_lw_nostall", 32'(stall), 32'd0);
    tick();
    set_d(5'd8, 5'd10, 3'd1, 3'd1, 5'd11, 1'b1, 3'd1);
    #1 chk("lu_stall", 32'(stall), 32'd1);
    chk("lu_fwd_rs_d_busy", 32'(fwd_rs_d), 32'd0);
    tick();
    #1 chk("lu_stall_released", 32'(stall), 32'd0);
    chk("lu_fwd_rs_d_notready", 32'(fwd_rs_d), 32'd0);
    tick();
    nop_d();
    #1 chk("lu_fwd_rs_e_w", 32'(fwd_rs_e), 32'd3);
    chk("lu_fwd_rt_e_rf", 32'(fwd_rt_e), 32'd0);
    flush();

    // Branch after ALU: addu $9 (Tnew 1) then beq on $9 with Tuse 0.
    set_d(5'd1, 5'd2, 3'd1, 3'd1, 5'd9, 1'b1, 3'd1);
    tick();
    set_d(5'd9, 5'd0, 3'd0, 3'd0, 5'd0, 1'b0, 3'd0);
    #1 chk("br_stall", 32'(stall), 32'd1);
    tick();
    #1 chk("br_stall_released", 32'(stall), 32'd0);
    chk("br_fwd_rs_d_m", 32'(fwd_rs_d), 32'd2);
    chk("br_fwd_rt_d_rf", 32'(fwd_rt_d), 32'd0);
    tick();
    nop_d();
    #1 chk("br_fwd_rs_e_w", 32'(fwd_rs_e), 32'd3);
    flush();

    // $0 destination never stalls or forwards.
    set_d(5'd0, 5'd0, 3'd7, 3'd7, 5'd0, 1'b1, 3'd2);
    tick();
    set_d(5'd0, 5'd0, 3'd0, 3'd0, 5'd0, 1'b0, 3'd0);
    #1 chk("zero_stall", 32'(stall), 32'd0);
    chk("zero_fwd_rs_d", 32'(fwd_rs_d), 32'd0);
    flush();

    // Unused operand (Tuse 4) against a busy producer, then a used one.
    set_d(5'd0, 5'd0, 3'd7, 3'd7, 5'd12, 1'b1, 3'd2);
    tick();
    set_d(5'd0, 5'd12, 3'd7, 3'd4, 5'd0, 1'b0, 3'd0);
    #1 chk("unused_rt_nostall", 32'(stall), 32'd0);
    set_d(5'd0, 5'd12, 3'd7, 3'd1, 5'd0, 1'b0, 3'd0);
    #1 chk("used_rt_stall", 32'(stall), 32'd1);
    flush();

    // Shadowing: older ready $5 hidden by younger not-ready $5.
    set_d(5'd0, 5'd0, 3'd7, 3'd7, 5'd5, 1'b1, 3'd1);
    tick();
    set_d(5'd0, 5'd0, 3'd7, 3'd7, 5'd5, 1'b1, 3'd1);
    #1 chk("sh_second_nostall", 32'(stall), 32'd0);
    tick();
    set_d(5'd5, 5'd0, 3'd0, 3'd7, 5'd0, 1'b0, 3'd0);
    #1 chk("sh_stall", 32'(stall), 32'd1);
    chk("sh_fwd_rs_d_none", 32'(fwd_rs_d), 32'd0);
    tick();
    #1 chk("sh_after_stall", 32'(stall), 32'd0);
    chk("sh_fwd_rs_d_youngest", 32'(fwd_rs_d), 32'd2);
    flush();

`ifdef HAZARD_MDU_EN
    // mult starts in E while mflo sits in D every cycle.
    md_d       = 1'b1;
    md_start_e = 2'b01;
    #1 chk("mdu_start_stall", 32'(stall), 32'd1);
    chk("mdu_start_busy", 32'(mdu_busy), 32'd0);
    tick();
    md_start_e = 2'b00;
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("mdu_stall_%0d", i), 32'(stall), 32'd1);
      chk($sformatf("mdu_busy_%0d", i), 32'(mdu_busy), 32'd1);
      tick();
    end
    #1 chk("mdu_done_stall", 32'(stall), 32'd0);
    chk("mdu_done_busy", 32'(mdu_busy), 32'd0);
    md_d = 1'b0;
    flush();
    md_start_e = 2'b10;
    tick();
    md_start_e = 2'b00;
    #1 chk("mdu_div_busy", 32'(mdu_busy), 32'd1);
`endif

    // Reset asserted mid-stall clears everything without a clock edge.
    set_d(5'd0, 5'd0, 3'd7, 3'd7, 5'd7, 1'b1, 3'd2);
    tick();
    set_d(5'd7, 5'd0, 3'd0, 3'd7, 5'd0, 1'b0, 3'd0);
    #1 chk("rst_pre_stall", 32'(stall), 32'd1);
    #1 reset = 1'b1;
    #1 chk("rst_async_stall", 32'(stall), 32'd0);
    chk("rst_async_fwd_rs_d", 32'(fwd_rs_d), 32'd0);
    chk("rst_async_fwd_rt_e", 32'(fwd_rt_e), 32'd0);
`ifdef HAZARD_MDU_EN
    chk("rst_async_busy", 32'(mdu_busy), 32'd0);
`endif
    tick();
    reset = 1'b0;
    #1 chk("rst_empty_stall", 32'(stall), 32'd0);
    chk("rst_empty_fwd_rs_d", 32'(fwd_rs_d), 32'd0);
    tick();
    #1 chk("rst_empty_next_stall", 32'(stall), 32'd0);
    chk("rst_empty_fwd_rs_e", 32'(fwd_rs_e), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the pipelined MIPS core: it tracks destination register, write-enable and Tnew for every in-flight instruction past Decode and produces the D-stage stall and the D/E forwarding selects. It sits beside the Decode-stage control decoder and consumes its A3, RFWE, Tuse and Tnew outputs. It generalises the fixed E/M/W scheme to a parametrised number of post-Decode stages. An optional multiply/divide busy tracker adds MDU-induced stalls.

## Interface
- NUM_STAGES, 3, post-Decode stages tracked (stage 0 = E, last = W); legal 2..6
- TW, 3, width of Tuse/Tnew fields
- MULT_LAT, 5, mult/multu busy cycles (MDU only)
- DIV_LAT, 10, div/divu busy cycles (MDU only)
- FW = $clog2(NUM_STAGES+1), forwarding-select width (derived)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- rs_d, rt_d  in  5  source registers of the D instruction
- tuse_rs_d, tuse_rt_d  in  TW  Tuse; value ≥ 4 means operand unused
- a3_d  in  5  destination of the D instruction
- rfwe_d  in  1  D instruction writes the register file
- tnew_d  in  TW  Tnew at E entry
- stall  out  1  hold PC/D register and insert a bubble into E
- fwd_rs_d, fwd_rt_d  out  FW  0 = register file, k+1 = result of stage k
- fwd_rs_e, fwd_rt_e  out  FW  same encoding, for E-stage operands; only stages ≥1 are selected
- md_d  in  1  D instruction is a mult/div/mfhi/mflo/mthi/mtlo (MDU only)
- md_start_e  in  2  01 = mult start in E, 10 = div start, 00 = none (MDU only)
- mdu_busy  out  1  MDU busy (MDU only)

## Operation
- Tracker: NUM_STAGES entries {rs, rt, a3, we, tnew}. Each edge: entry 0 <= bubble (all zero) when stall, else the D fields; entry k+1 <= entry k with tnew = max(tnew−1, 0).
- Valid producer at stage k: we=1, a3≠0, a3 equals the source register.
- For each D source, only the youngest (lowest k) valid producer counts; older matches are shadowed.
- stall = 1 if that producer has tnew > tuse for either D source (tuse ≥ 4 never stalls).
- fwd_*_d = k+1 if that youngest producer has tnew==0, else 0.
- fwd_*_e: same search for entry 0's rs/rt over stages 1..NUM_STAGES−1; selects k+1 only when tnew==0, else 0.
- Writes to $0 never stall and never forward.

## Timing
- stall and fwd_* are combinational from the D inputs and registered tracker state, valid in the same cycle.
- Reset: all entries become bubbles and the MDU counter clears, so stall=0, all fwd_*=0 and mdu_busy=0 immediately, without waiting for a clock edge.
- Reset asserted mid-stall aborts the stall. Behaviour after reset is identical to power-up.
- Stalls are one cycle each and re-evaluate every cycle. A load-use hazard with Tuse=1 stalls exactly one cycle.

## Configuration
- HAZARD_MDU_EN defined: MDU ports exist and sub-module mdu_busy_counter is instantiated.
  - md_start_e=01 loads MULT_LAT; md_start_e=10 loads DIV_LAT. The counter then decrements each cycle to 0.
  - mdu_busy = (count≠0).
  - stall additionally asserts when md_d & (mdu_busy | md_start_e≠0).
  - A start while already busy reloads the counter.
- Undefined: MDU ports, the counter and the MDU stall term are absent.

## Structure
- hazard_pkg holds the tracker-entry struct typedef, TUSE_NONE=4, the fwd encoding constants, and the MDU start-code constants.
- One sub-module: mdu_busy_counter (count register, load/decrement logic, busy flag). The tracker and the comparators live in hazard_unit.

## Test plan
- Load-use: D=lw a3=8, tnew=2, then D=addu rs=8, tuse_rs=1.
  - Expected: stall=1 for one cycle.
  - Expected: when addu reaches E, fwd_rs_e=3 (lw in W).
- Branch after ALU: E holds addu a3=9, tnew=1; D=beq rs=9, tuse=0.
  - Expected: stall=1 for one cycle, then fwd_rs_d=2.
- $0 and unused operand:
  - Producer a3=0, tnew=2 and D rs=0, tuse=0 → stall=0, fwd=0.
  - D tuse_rt=4 with a matching busy producer → stall=0.
- Shadowing: stage 1 writes $5 with tnew=0 and stage 0 writes $5 with tnew=1; D rs=5, tuse=0.
  - Expected: stall=1 and fwd_rs_d=0; stage 1 is never selected.
- MDU (HAZARD_MDU_EN): mult start, then D=mflo every cycle.
  - Expected: stall asserted in the start cycle and for the following 5 cycles; mdu_busy high for 5 cycles.
- Reset mid-stall: assert reset while stall=1.
  - Expected: stall, fwd_* and mdu_busy are 0 asynchronously.
  - Expected: the tracker is empty after release.
